reflet_pwm_fade: RTL and testbench

- Upstream stage of reflet_pwm_pwm. Generates that block's duty_cycle input.
- Ramps the current duty value toward a loaded target in fixed steps, one step every programmable number of clock cycles. Used for LED fades and soft-start of loads.
- Target, step and rate come from the PWM peripheral register file as a one-cycle load strobe.
- Reports busy and done status back to the register file.

---
 rtl/reflet_pwm_pkg.sv | 13 +
 rtl/reflet_pwm_fade_if.sv | 28 ++
 rtl/reflet_pwm_fade_prescaler.sv | 38 +++
 rtl/reflet_pwm_fade.sv | 99 +++++++++
 tb/tb_reflet_pwm_fade.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/reflet_pwm_pkg.sv
// rtl/reflet_pwm_pkg.sv - shared state encoding and default widths for the PWM fade path
package reflet_pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_RATE_WIDTH = 16;

endpackage

// File: rtl/reflet_pwm_fade_if.sv
// rtl/reflet_pwm_fade_if.sv - register-file side load bundle and status returned by the fade block
interface reflet_pwm_fade_if
  import reflet_pwm_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int RATE_WIDTH = DEF_RATE_WIDTH
) ();

  logic                  load;
  logic [WIDTH-1:0]      target;
  logic [WIDTH-1:0]      step;
  logic [RATE_WIDTH-1:0] rate;
  logic [WIDTH-1:0]      max;
  logic [WIDTH-1:0]      duty_cycle;
  logic                  busy;
  logic                  done;

  modport master (
    output load, target, step, rate, max,
    input  duty_cycle, busy, done
  );

  modport slave (
    input  load, target, step, rate, max,
    output duty_cycle, busy, done
  );

endinterface

// File: rtl/reflet_pwm_fade_prescaler.sv
// rtl/reflet_pwm_fade_prescaler.sv - update-rate counter, one-cycle tick when the count reaches rate
module reflet_pwm_fade_prescaler
  import reflet_pwm_pkg::*;
#(
  parameter int RATE_WIDTH = DEF_RATE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic [RATE_WIDTH-1:0] rate,
  output logic                  tick
);

  logic [RATE_WIDTH-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == rate);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + RATE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reflet_pwm_fade.sv
// rtl/reflet_pwm_fade.sv - duty ramp toward a clamped target; REFLET_PWM_FADE_LOG_EN enables duty-scaled steps
module reflet_pwm_fade
  import reflet_pwm_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int RATE_WIDTH = DEF_RATE_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  reflet_pwm_fade_if.slave  bus
);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      duty_q, duty_d;
  logic [WIDTH-1:0]      tgt_q, tgt_d;
  logic [WIDTH-1:0]      step_q, step_d;
  logic [RATE_WIDTH-1:0] rate_q, rate_d;
  logic                  done_q, done_d;
  logic                  tick, ramping;
  logic [WIDTH-1:0]      tgt_clamp, eff_step, next_up, next_dn;
  logic [WIDTH:0]        dist_up, dist_dn;

  assign ramping   = (state_q != ST_IDLE);
  assign tgt_clamp = (bus.target > bus.max) ? bus.max : bus.target;
  assign dist_up   = {1'b0, tgt_q} - {1'b0, duty_q};
  assign dist_dn   = {1'b0, duty_q} - {1'b0, tgt_q};

`ifdef REFLET_PWM_FADE_LOG_EN
  assign eff_step = (step_q > (duty_q >> 3)) ? step_q : (duty_q >> 3);
`else
  assign eff_step = step_q;
`endif

  // A zero step lands on the target at the first update rather than stalling.
  assign next_up = ((eff_step == '0) || (dist_up <= {1'b0, eff_step})) ? tgt_q : duty_q + eff_step;
  assign next_dn = ((eff_step == '0) || (dist_dn <= {1'b0, eff_step})) ? tgt_q : duty_q - eff_step;

  reflet_pwm_fade_prescaler #(
    .RATE_WIDTH(RATE_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (bus.load),
    .en   (ramping),
    .rate (rate_q),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    rate_d  = rate_q;
    done_d  = 1'b0;
    if (bus.load) begin
      tgt_d  = tgt_clamp;
      step_d = bus.step;
      rate_d = bus.rate;
      if (tgt_clamp > duty_q) begin
        state_d = ST_UP;
      end else if (tgt_clamp < duty_q) begin
        state_d = ST_DOWN;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (tick) begin
      duty_d = (state_q == ST_UP) ? next_up : next_dn;
      if (duty_d == tgt_q) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      rate_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      rate_q  <= rate_d;
      done_q  <= done_d;
    end
  end

  assign bus.duty_cycle = duty_q;
  assign bus.busy       = ramping;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_reflet_pwm_fade.sv
// tb/tb_reflet_pwm_fade.sv - directed scoreboard bench for reflet_pwm_fade
module tb_reflet_pwm_fade;
  import reflet_pwm_pkg::*;

  localparam int W  = 8;
  localparam int RW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reflet_pwm_fade_if #(.WIDTH(W), .RATE_WIDTH(RW)) bus ();

  reflet_pwm_fade #(.WIDTH(W), .RATE_WIDTH(RW)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         load_cyc = 0;
  int         done_cnt = 0;
  int         d0;
  int         n;
  int         mdl;
  int         eff;
  logic [W-1:0] exp_q[$];
  int         obs_cyc[$];
  logic [W-1:0] prev_duty = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every duty change pops the next expected value.
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.duty_cycle !== prev_duty) begin
      obs_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_change", 32'(bus.duty_cycle), 32'(prev_duty));
      else check("duty", 32'(bus.duty_cycle), 32'(exp_q.pop_front()));
      prev_duty = bus.duty_cycle;
    end
  end

  task automatic do_load(input int t, input int s, input int r);
    bus.target = W'(t);
    bus.step   = W'(s);
    bus.rate   = RW'(r);
    bus.load   = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    load_cyc = cyc;
  endtask

  task automatic wait_settle(input string tag, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || bus.busy !== 1'b0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_timeout"}, 32'(k < budget), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_duty(input int v, input int budget);
    int k = 0;
    while (bus.duty_cycle !== W'(v) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_duty_timeout", 32'(k < budget), 32'd1);
  endtask

  initial begin
    bus.load = 1'b0; bus.target = '0; bus.step = '0; bus.rate = '0; bus.max = 8'd10;
    repeat (3) @(negedge clk);
    check("rst_duty", 32'(bus.duty_cycle), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_duty", 32'(bus.duty_cycle), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Ramp up 0 -> 9, step 2, one update every 4 cycles.
    d0 = done_cnt;
    obs_cyc.delete();
    exp_q.push_back(8'd2); exp_q.push_back(8'd4); exp_q.push_back(8'd6);
    exp_q.push_back(8'd8); exp_q.push_back(8'd9);
    do_load(9, 2, 3);
    check("up_busy_rise", 32'(bus.busy), 32'd1);
    wait_settle("up", 60);
    check("up_nchg", 32'(obs_cyc.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs_cyc.size(); i++)
      check("up_timing", 32'(obs_cyc[i]), 32'(load_cyc + 4 * (i + 1)));
    check("up_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("up_busy_fall", 32'(bus.busy), 32'd0);

    // Ramp down 9 -> 1, step 3, every clock.
    d0 = done_cnt;
    obs_cyc.delete();
    exp_q.push_back(8'd6); exp_q.push_back(8'd3); exp_q.push_back(8'd1);
    do_load(1, 3, 0);
    wait_settle("down", 30);
    check("down_nchg", 32'(obs_cyc.size()), 32'd3);
    for (int i = 0; i < 3 && i < obs_cyc.size(); i++)
      check("down_timing", 32'(obs_cyc[i]), 32'(load_cyc + i + 1));
    check("down_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Target above max is clamped; step 0 jumps straight there.
    obs_cyc.delete();
    exp_q.push_back(8'd10);
    do_load(200, 0, 5);
    wait_settle("clamp", 30);
    check("clamp_duty", 32'(bus.duty_cycle), 32'd10);
    check("clamp_timing", 32'(obs_cyc.size() > 0 ? obs_cyc[0] : -1), 32'(load_cyc + 6));

    // Back to 0, then reverse a rising ramp at duty 4.
    exp_q.push_back(8'd0);
    do_load(0, 10, 0);
    wait_settle("to_zero", 30);
    d0 = done_cnt;
    exp_q.push_back(8'd2); exp_q.push_back(8'd4);
    do_load(9, 2, 3);
    wait_duty(4, 40);
    exp_q.push_back(8'd3); exp_q.push_back(8'd2); exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    do_load(0, 1, 0);
    wait_settle("reverse", 40);
    check("reverse_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Asynchronous reset mid-ramp.
    exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    do_load(10, 1, 2);
    wait_duty(2, 40);
    exp_q.push_back(8'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_duty", 32'(bus.duty_cycle), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_duty", 32'(bus.duty_cycle), 32'd0);
    check("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

    // Load equal to the current duty: no busy, single done.
    d0 = done_cnt;
    do_load(0, 5, 1);
    check("eq_busy", 32'(bus.busy), 32'd0);
    check("eq_done_hi", 32'(bus.done), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("eq_done_lo", 32'(bus.done), 32'd0);
    repeat (3) @(negedge clk);
    check("eq_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("eq_busy_after", 32'(bus.busy), 32'd0);

    // Full-range ramp 128 -> 255 with step 1.
    bus.max = 8'd255;
    exp_q.push_back(8'd128);
    do_load(128, 128, 0);
    wait_settle("to_128", 30);
    mdl = 128;
    while (mdl != 255) begin
      eff = 1;
`ifdef REFLET_PWM_FADE_LOG_EN
      if ((mdl >> 3) > eff) eff = mdl >> 3;
`endif
      mdl = (255 - mdl <= eff) ? 255 : mdl + eff;
      exp_q.push_back(W'(mdl));
    end
    d0 = done_cnt;
    do_load(255, 1, 0);
    wait_settle("full", 400);
    check("full_duty", 32'(bus.duty_cycle), 32'd255);
    check("full_done_cnt", 32'(done_cnt - d0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
